dcache_assoc: RTL and testbench

Parametrised write-back, write-allocate data cache between the datapath memory port and the memory controller. It generalises the fixed 2-way, 8-set, 2-word dcache to configurable ways, sets and block size. It adds per-set true-LRU replacement, multi-beat burst fill and write-back, and hit/miss counters. A halt-triggered flush walks every set and way and writes back dirty blocks before asserting flushed.

---
 rtl/dcache_cfg_pkg.sv | 35 +++
 rtl/dcache_lru.sv | 44 ++++
 rtl/dcache_assoc.sv | 247 ++++++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_cfg_pkg.sv
// rtl/dcache_cfg_pkg.sv - shared widths, FSM states and helpers for dcache_assoc
// Purpose: derives address-field widths from the cache geometry and defines the
//          controller state encoding. No ports.
package dcache_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WB         = 3'd1,
    ST_FILL       = 3'd2,
    ST_FLUSH_SCAN = 3'd3,
    ST_FLUSH_WB   = 3'd4,
    ST_FLUSHED    = 3'd5
  } dcache_state_t;

  // Word-within-block offset width.
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  // Set index width.
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag width: 32-bit byte address minus the two byte-select bits.
  function automatic int tag_w(input int sets, input int words);
    return 30 - $clog2(sets) - $clog2(words);
  endfunction

  // Way-select / LRU-age width; kept at least 1 bit so WAYS=1 still elaborates.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// rtl/dcache_lru.sv - true-LRU age update and victim selection for one set
// Purpose: given one set's age vector (0 = most recent), picks the victim and
//          produces the ages after an optional touch.
// Ports: age_i    current ages, one per way
//        valid_i  valid mask of the set
//        touch_i  the set is being hit this cycle
//        way_i    way being hit
//        victim_o lowest invalid way, else the oldest way
//        age_o    ages after applying the touch
module dcache_lru #(
  parameter int WAYS = 2,
  parameter int WW   = 1
) (
  input  logic [WAYS-1:0][WW-1:0] age_i,
  input  logic [WAYS-1:0]         valid_i,
  input  logic                    touch_i,
  input  logic [WW-1:0]           way_i,
  output logic [WW-1:0]           victim_o,
  output logic [WAYS-1:0][WW-1:0] age_o
);

  // Ages form a permutation of 0..WAYS-1, so exactly one way holds WAYS-1.
  // The invalid scan runs downwards so the lowest-numbered invalid way wins.
  always_comb begin
    victim_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_i[w] == WW'(WAYS - 1)) victim_o = WW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = WW'(w);
    end
  end

  always_comb begin
    age_o = age_i;
    if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == way_i) age_o[w] = '0;
        else if (age_i[w] < age_i[way_i]) age_o[w] = age_i[w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - parametrised write-back, write-allocate set-associative data cache
// Purpose: services datapath loads/stores, fills and writes back blocks in
//          WORDS-beat bursts, and flushes all dirty blocks on halt.
// Ports: CLK/nRST                          clock, async active-low reset
//        dmemREN/dmemWEN/dmemaddr/dmemstore datapath request (write wins)
//        halt                              start the flush walk
//        dhit/dmemload                     request satisfied / read data
//        flushed                           flush complete, sticky
//        dREN/dWEN/daddr/dstore/dload/dwait memory-side burst port
//        hit_count/miss_count              dhit cycles / completed fills
module dcache_assoc
  import dcache_cfg_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OW = off_w(WORDS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(SETS, WORDS);
  localparam int WW = way_w(WAYS);

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [TW-1:0]          tag;
    logic [WORDS-1:0][31:0] data;
  } blk_t;

  blk_t                   blk_q [WAYS][SETS];
  logic [WAYS-1:0][WW-1:0] age_q [SETS];
  dcache_state_t          state_q, state_d;
  logic [OW-1:0]          beat_q;
  logic [WW-1:0]          victim_q, way_q;
  logic [IW-1:0]          idx_q, set_q;
  logic [TW-1:0]          tag_q;
  logic [31:0]            hit_q, miss_q;

  logic [OW-1:0]          req_off;
  logic [IW-1:0]          req_idx;
  logic [TW-1:0]          req_tag;
  logic                   req, access, hit, last_beat, last_slot, slot_dirty;
  logic [WW-1:0]          hit_way, victim, way_nxt;
  logic [IW-1:0]          set_nxt;
  logic [WAYS-1:0]        valid_mask;
  logic [WAYS-1:0][WW-1:0] age_nxt;
  blk_t                   cur_blk;
  logic                   unused_byte_sel;

  assign unused_byte_sel = ^dmemaddr[1:0];
  assign req_off   = dmemaddr[2 +: OW];
  assign req_idx   = dmemaddr[2 + OW +: IW];
  assign req_tag   = dmemaddr[31 -: TW];
  assign req       = dmemREN | dmemWEN;
  // halt has priority: a request arriving with halt is left unserviced.
  assign access    = (state_q == ST_IDLE) && !halt && req;
  assign last_beat = (beat_q == OW'(WORDS - 1));
  assign cur_blk   = blk_q[way_q][set_q];
  assign slot_dirty = cur_blk.valid && cur_blk.dirty;
  assign last_slot = (set_q == IW'(SETS - 1)) && (way_q == WW'(WAYS - 1));
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    valid_mask = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_mask[w] = blk_q[w][req_idx].valid;
      if (blk_q[w][req_idx].valid && (blk_q[w][req_idx].tag == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Flush walk order: way is the inner loop, set the outer.
  always_comb begin
    way_nxt = way_q + 1'b1;
    set_nxt = set_q;
    if (way_q == WW'(WAYS - 1)) begin
      way_nxt = '0;
      set_nxt = set_q + 1'b1;
    end
  end

  dcache_lru #(.WAYS(WAYS), .WW(WW)) u_lru (
    .age_i   (age_q[req_idx]),
    .valid_i (valid_mask),
    .touch_i (dhit),
    .way_i   (hit_way),
    .victim_o(victim),
    .age_o   (age_nxt)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (halt) state_d = ST_FLUSH_SCAN;
        else if (req && !hit)
          state_d = (blk_q[victim][req_idx].valid && blk_q[victim][req_idx].dirty) ? ST_WB : ST_FILL;
      end
      ST_WB:         if (!dwait && last_beat) state_d = ST_FILL;
      ST_FILL:       if (!dwait && last_beat) state_d = ST_IDLE;
      ST_FLUSH_SCAN: begin
        if (slot_dirty)     state_d = ST_FLUSH_WB;
        else if (last_slot) state_d = ST_FLUSHED;
      end
      ST_FLUSH_WB:   if (!dwait && last_beat) state_d = last_slot ? ST_FLUSHED : ST_FLUSH_SCAN;
      default:       state_d = state_q;
    endcase
  end

  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    flushed  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dhit = access && hit;
        if (dhit) dmemload = blk_q[hit_way][req_idx].data[req_off];
      end
      ST_WB: begin
        dWEN   = 1'b1;
        daddr  = {blk_q[victim_q][idx_q].tag, idx_q, beat_q, 2'b00};
        dstore = blk_q[victim_q][idx_q].data[beat_q];
      end
      ST_FILL: begin
        dREN  = 1'b1;
        daddr = {tag_q, idx_q, beat_q, 2'b00};
      end
      ST_FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = {cur_blk.tag, set_q, beat_q, 2'b00};
        dstore = cur_blk.data[beat_q];
      end
      ST_FLUSHED: flushed = 1'b1;
      default: ;
    endcase
  end

  // beat_q wraps to 0 after the last beat because WORDS is a power of 2.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          blk_q[w][s] <= '0;
          age_q[s][w] <= WW'(w);
        end
      end
      beat_q   <= '0;
      victim_q <= '0;
      way_q    <= '0;
      set_q    <= '0;
      idx_q    <= '0;
      tag_q    <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (halt) begin
            set_q <= '0;
            way_q <= '0;
          end else if (req) begin
            if (hit) begin
              hit_q          <= hit_q + 32'd1;
              age_q[req_idx] <= age_nxt;
              if (dmemWEN) begin
                blk_q[hit_way][req_idx].data[req_off] <= dmemstore;
                blk_q[hit_way][req_idx].dirty         <= 1'b1;
              end
            end else begin
              victim_q <= victim;
              idx_q    <= req_idx;
              tag_q    <= req_tag;
              beat_q   <= '0;
            end
          end
        end
        ST_WB: if (!dwait) beat_q <= beat_q + 1'b1;
        ST_FILL: begin
          if (!dwait) begin
            blk_q[victim_q][idx_q].data[beat_q] <= dload;
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              blk_q[victim_q][idx_q].valid <= 1'b1;
              blk_q[victim_q][idx_q].dirty <= 1'b0;
              blk_q[victim_q][idx_q].tag   <= tag_q;
              miss_q <= miss_q + 32'd1;
            end
          end
        end
        ST_FLUSH_SCAN: begin
          beat_q <= '0;
          if (!slot_dirty) begin
            way_q <= way_nxt;
            set_q <= set_nxt;
          end
        end
        ST_FLUSH_WB: begin
          if (!dwait) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              blk_q[way_q][set_q].valid <= 1'b0;
              blk_q[way_q][set_q].dirty <= 1'b0;
              way_q <= way_nxt;
              set_q <= set_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - scoreboard bench for dcache_assoc with a stalling memory model
module tb_dcache_assoc;

  logic        CLK, nRST, dmemREN, dmemWEN, halt, dwait;
  logic [31:0] dmemaddr, dmemstore, dload;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore, hit_count, miss_count;

  dcache_assoc #(.WAYS(2), .SETS(8), .WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct { logic ren; logic wen; logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { bit chk; logic [31:0] data; } hit_t;

  beat_t       bus_q[$];
  hit_t        hit_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall_n  = 0;
  int          exp_hits = 0;
  int          exp_miss = 0;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic exp_rd(input logic [31:0] a);
    beat_t b;
    b.ren = 1; b.wen = 0; b.addr = a; b.data = '0;
    bus_q.push_back(b);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.ren = 0; b.wen = 1; b.addr = a; b.data = d;
    bus_q.push_back(b);
  endtask

  task automatic exp_hit(input bit c, input logic [31:0] d);
    hit_t h;
    h.chk = c; h.data = d;
    hit_q.push_back(h);
  endtask

  // Memory model + monitor: answers bursts with optional stalls and checks
  // every strobed cycle and every dhit against the scoreboard queues.
  initial begin : monitor
    int    stall_cnt;
    hit_t  h;
    beat_t b;
    stall_cnt = 0;
    dwait = 0;
    dload = '0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        dwait = 0;
        stall_cnt = 0;
      end else begin
        if (dhit) begin
          if (hit_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected dhit: addr %h required no hit", dmemaddr);
          end else begin
            h = hit_q.pop_front();
            if (h.chk) chk("dmemload", dmemload, h.data);
          end
        end
        if (dREN || dWEN) begin
          if (dREN) dload = memrd(daddr);
          if (stall_cnt < stall_n) begin
            dwait = 1; stall_cnt++;
          end else begin
            dwait = 0; stall_cnt = 0;
          end
          if (bus_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected bus beat: ren %0b wen %0b addr %h required none", dREN, dWEN, daddr);
          end else begin
            b = bus_q[0];
            chk("bus strobes", {30'd0, dREN, dWEN}, {30'd0, b.ren, b.wen});
            chk("daddr", daddr, b.addr);
            if (b.wen) chk("dstore", dstore, b.data);
            if (!dwait) begin
              bus_q.delete(0);
              if (dWEN) mem[daddr] = dstore;
            end
          end
        end else begin
          dwait = 0;
          stall_cnt = 0;
        end
      end
    end
  end

  // Holds a request until dhit and checks the cycle count to it.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input bit miss);
    int n;
    bit got;
    n = 0; got = 0;
    dmemaddr = a; dmemstore = d; dmemWEN = wr; dmemREN = !wr;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge CLK);
      if (dhit) got = 1;
      else n++;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL dhit timeout: addr %h got no hit required latency %0d", a, lat);
    end else begin
      chk("hit latency", 32'(n), 32'(lat));
    end
    @(posedge CLK); #1;
    dmemREN = 0; dmemWEN = 0;
    exp_hits++;
    if (miss) exp_miss++;
  endtask

  initial begin : stim
    nRST = 0; dmemREN = 0; dmemWEN = 0; dmemaddr = '0; dmemstore = '0; halt = 0;
    mem[32'h100] = 32'hA;
    mem[32'h104] = 32'hB;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset dhit", {31'd0, dhit}, 32'd0);
    chk("reset dREN", {31'd0, dREN}, 32'd0);
    chk("reset dWEN", {31'd0, dWEN}, 32'd0);
    chk("reset daddr", daddr, 32'd0);
    chk("reset dstore", dstore, 32'd0);
    chk("reset dmemload", dmemload, 32'd0);
    chk("reset flushed", {31'd0, flushed}, 32'd0);
    chk("reset hit_count", hit_count, 32'd0);
    chk("reset miss_count", miss_count, 32'd0);
    nRST = 1;
    @(posedge CLK); #1;

    // Cold miss, then same-block hit.
    exp_rd(32'h100); exp_rd(32'h104); exp_hit(1, 32'hA);
    access(0, 32'h100, 0, 3, 1);
    exp_hit(1, 32'hB);
    access(0, 32'h104, 0, 0, 0);
    chk("miss_count t1", miss_count, 32'd1);
    chk("hit_count t1", hit_count, 32'd2);

    // LRU in set 3: A, B, touch A, C evicts B.
    exp_rd(32'h218); exp_rd(32'h21C); exp_hit(1, 32'hC0DE0218);
    access(0, 32'h218, 0, 3, 1);
    exp_rd(32'h258); exp_rd(32'h25C); exp_hit(1, 32'hC0DE0258);
    access(0, 32'h258, 0, 3, 1);
    exp_hit(1, 32'hC0DE0218);
    access(0, 32'h218, 0, 0, 0);
    exp_rd(32'h298); exp_rd(32'h29C); exp_hit(1, 32'hC0DE0298);
    access(0, 32'h298, 0, 3, 1);
    exp_hit(1, 32'hC0DE0218);
    access(0, 32'h218, 0, 0, 0);
    exp_rd(32'h258); exp_rd(32'h25C); exp_hit(1, 32'hC0DE0258);
    access(0, 32'h258, 0, 3, 1);

    // Dirty eviction: write back 0xDEAD and the old word before the fill.
    exp_hit(0, 32'h0);
    access(1, 32'h100, 32'hDEAD, 0, 0);
    exp_rd(32'h140); exp_rd(32'h144); exp_hit(1, 32'hC0DE0140);
    access(0, 32'h140, 0, 3, 1);
    exp_wr(32'h100, 32'hDEAD); exp_wr(32'h104, 32'hB);
    exp_rd(32'h180); exp_rd(32'h184); exp_hit(1, 32'hC0DE0180);
    access(0, 32'h180, 0, 5, 1);

    // Five stall cycles on every beat, clean fill then dirty eviction.
    stall_n = 5;
    exp_hit(0, 32'h0);
    access(1, 32'h140, 32'hBEEF, 0, 0);
    exp_rd(32'h1C0); exp_rd(32'h1C4); exp_hit(1, 32'hC0DE01C0);
    access(0, 32'h1C0, 0, 13, 1);
    exp_wr(32'h140, 32'hBEEF); exp_wr(32'h144, 32'hC0DE0144);
    exp_rd(32'h200); exp_rd(32'h204); exp_hit(1, 32'hC0DE0200);
    access(0, 32'h200, 0, 25, 1);
    stall_n = 0;
    chk("hit_count t4", hit_count, 32'(exp_hits));
    chk("miss_count t4", miss_count, 32'(exp_miss));

    // Dirty lines in sets 0 and 7, then halt-triggered flush.
    exp_hit(0, 32'h0);
    access(1, 32'h1C4, 32'h1111, 0, 0);
    exp_rd(32'h038); exp_rd(32'h03C); exp_hit(0, 32'h0);
    access(1, 32'h03C, 32'h2222, 3, 1);
    chk("hit_count t5", hit_count, 32'd16);
    chk("miss_count t5", miss_count, 32'd10);
    exp_wr(32'h1C0, 32'hC0DE01C0); exp_wr(32'h1C4, 32'h1111);
    exp_wr(32'h038, 32'hC0DE0038); exp_wr(32'h03C, 32'h2222);
    halt = 1;
    for (int k = 0; k < 200 && !flushed; k++) @(negedge CLK);
    chk("flushed set", {31'd0, flushed}, 32'd1);
    chk("flush beats outstanding", 32'(bus_q.size()), 32'd0);
    dmemaddr = 32'h1C0; dmemREN = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("flushed held", {31'd0, flushed}, 32'd1);
      chk("no dhit after flush", {31'd0, dhit}, 32'd0);
      chk("no strobes after flush", {30'd0, dREN, dWEN}, 32'd0);
    end
    @(posedge CLK); #1;
    dmemREN = 0; halt = 0;

    // Reset clears flushed/counters; then reset in the middle of a fill.
    nRST = 0;
    @(posedge CLK); #1;
    nRST = 1;
    #1;
    chk("flushed after reset", {31'd0, flushed}, 32'd0);
    chk("hit_count after reset", hit_count, 32'd0);
    chk("miss_count after reset", miss_count, 32'd0);
    exp_hits = 0; exp_miss = 0;
    @(posedge CLK); #1;
    exp_rd(32'h100); exp_rd(32'h104);
    dmemaddr = 32'h100; dmemREN = 1;
    repeat (3) @(negedge CLK);
    chk("second fill beat dREN", {31'd0, dREN}, 32'd1);
    chk("second fill beat daddr", daddr, 32'h104);
    #2 nRST = 0;
    #1;
    chk("dREN drops on reset", {31'd0, dREN}, 32'd0);
    chk("daddr cleared on reset", daddr, 32'd0);
    bus_q.delete();
    hit_q.delete();
    @(posedge CLK); #1;
    nRST = 1;
    exp_rd(32'h100); exp_rd(32'h104); exp_hit(1, 32'hDEAD);
    access(0, 32'h100, 0, 3, 1);
    chk("miss_count after refill", miss_count, 32'(exp_miss));
    chk("hit_count after refill", hit_count, 32'(exp_hits));
    chk("bus queue drained", 32'(bus_q.size()), 32'd0);
    chk("hit queue drained", 32'(hit_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
